hilo_iter_divider: RTL
======================

Name: hilo_iter_divider

Overview:
- Multicycle radix-2 restoring divider that feeds the Execute-stage ALU.
- It produces the 32-bit quotient and remainder that the ALU commits into HILO (HI=Remainder, LO=Quotient). It also raises a busy/stall flag that the ALU uses to detect completion and to hold HILO accessors.
- It runs in the background: the pipeline advances while it computes, and only HILO readers and writers wait.

Parameters:
- WIDTH, 32, operand/result width; only 32 is supported by the ALU; the counter is clog2(WIDTH) bits.

Ports:
- clock  in  1  Core clock; all state updates on the rising edge.
- reset  in  1  Asynchronous, active-low reset (0 = reset asserted).
- OP_div  in  1  Start a signed divide; sampled on the rising edge while idle.
- OP_divu  in  1  Start an unsigned divide; sampled on the rising edge while idle.
- Dividend  in  WIDTH  Dividend (rs); captured on the start edge only.
- Divisor  in  WIDTH  Divisor (rt); captured on the start edge only.
- Quotient  out  WIDTH  Sign-corrected quotient; valid when Stall=0 after a completed operation.
- Remainder  out  WIDTH  Sign-corrected remainder; valid alongside Quotient.
- Stall  out  1  1 while a divide is in progress.

Behaviour:
- Reset (reset=0, async): state=IDLE, count=0, all internal regs=0, neg_q=neg_r=0. Outputs: Stall=0, Quotient=0, Remainder=0.
- Reset asserted mid-operation: the operation is aborted immediately with no partial result retained. The first start after reset release behaves normally.
- States: IDLE and BUSY only. Stall = (state==BUSY), decoded from a state flop with no input dependence.
- Start (IDLE, OP_div|OP_divu at a rising edge):
  - OP_div has priority if both are high.
  - Capture quo_sr=|Dividend| and dvsr=|Divisor|. Absolute values apply for signed only; unsigned captures raw.
  - Set rem=0, count=WIDTH-1, state=BUSY.
  - Latch sign flags: neg_q = signed & (Dividend[31]^Divisor[31]); neg_r = signed & Dividend[31]. Both are 0 for unsigned.
- BUSY iteration, one bit per cycle:
  - trial = {rem, quo_sr[31]} - {1'b0, dvsr}, computed at 33 bits.
  - If trial[32]==0: rem=trial[31:0], quo_sr={quo_sr[30:0],1}.
  - Otherwise: rem={rem[30:0],quo_sr[31]}, quo_sr={quo_sr[30:0],0}.
  - count decrements each cycle. On the edge where count==0 the last iteration is performed and state goes to IDLE.
- Latency: Stall is high for exactly 32 cycles, starting the cycle after the start edge. Results are valid in the first cycle Stall=0.
- Output correction (combinational from registers):
  - Quotient = neg_q ? -quo_sr : quo_sr.
  - Remainder = neg_r ? -rem : rem.
  - Quotient and Remainder hold until the next start edge.
- Starts while BUSY (OP_div/OP_divu high) are ignored; operands are not recaptured. The ALU will not issue one.
- Start on the same edge Stall falls: it is accepted only when the state is already IDLE at that edge. No back-to-back overlap.
- Width rules and corner cases:
  - |x| of 0x80000000 is 0x80000000, treated as unsigned magnitude.
  - 0x80000000 / 0xFFFFFFFF signed gives Q=0x80000000, R=0.
- Divide by zero (architecturally unpredictable; the output is defined as the natural result):
  - Magnitude result is Q=0xFFFFFFFF, R=|Dividend|, then sign correction applies.
  - Unsigned: Q=0xFFFFFFFF, R=Dividend.
- No overflow or exception output; MIPS32 division never traps.

Test Plan:
- Reset, then OP_divu with 100 / 7 → Stall=1 for exactly 32 cycles, then Stall=0 with Quotient=0x0000000E, Remainder=0x00000002.
- OP_div with 0xFFFFFFF9 (-7) / 0x00000002 → Q=0xFFFFFFFD (-3), R=0xFFFFFFFF (-1). The same operands with OP_divu → Q=0x7FFFFFFC, R=0x00000001.
- OP_div with 0x80000000 / 0xFFFFFFFF → Q=0x80000000, R=0. OP_divu with 0xFFFFFFFF / 0x00000010 → Q=0x0FFFFFFF, R=0x0000000F.
- Divide by zero:
  - OP_divu 0x12345678 / 0 → Q=0xFFFFFFFF, R=0x12345678.
  - OP_div 0xFFFFFFF9 / 0 → Q=0x00000001, R=0xFFFFFFF9.
- Start 100/7, pulse OP_div with 50/5 at busy cycle 5 → ignored; the final result is still Q=14, R=2 at cycle 32. OP_div and OP_divu high together on 0xFFFFFFF9 / 2 → signed result (Q=0xFFFFFFFD).
- Start 100/7, drive reset=0 asynchronously (between clock edges) at busy cycle 10:
  - Stall, Quotient and Remainder go to 0 immediately.
  - After release, OP_divu 9 / 3 → Q=3, R=0 after 32 stall cycles.

Source files
------------

// File: rtl/hilo_iter_divider.sv
// Radix-2 restoring divider for the Execute-stage HILO unit: one quotient bit per cycle,
// 32 busy cycles per operation, with sign correction applied combinationally on the outputs.
module hilo_iter_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             OP_div,
    input  logic             OP_divu,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             Stall
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state, state_next;
    logic [CW-1:0]    count, count_next;
    logic [WIDTH-1:0] quo_sr, quo_sr_next;
    logic [WIDTH-1:0] dvsr, dvsr_next;
    logic [WIDTH-1:0] rem, rem_next;
    logic             neg_q, neg_q_next;
    logic             neg_r, neg_r_next;

    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend_abs;
    logic [WIDTH-1:0] divisor_abs;
    logic [WIDTH:0]   trial;

    // OP_div wins when both starts are raised together.
    assign start     = OP_div | OP_divu;
    assign is_signed = OP_div;

    // The most negative value negates to itself and is then read as an unsigned magnitude.
    assign dividend_abs = (is_signed && Dividend[WIDTH-1]) ? -Dividend : Dividend;
    assign divisor_abs  = (is_signed && Divisor[WIDTH-1])  ? -Divisor  : Divisor;

    // Bit WIDTH of the trial subtraction is the borrow: set means the divisor did not fit.
    assign trial = {rem, quo_sr[WIDTH-1]} - {1'b0, dvsr};

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next  = state;
        count_next  = count;
        quo_sr_next = quo_sr;
        dvsr_next   = dvsr;
        rem_next    = rem;
        neg_q_next  = neg_q;
        neg_r_next  = neg_r;

        case (state)
            IDLE: begin
                if (start) begin
                    quo_sr_next = dividend_abs;
                    dvsr_next   = divisor_abs;
                    rem_next    = '0;
                    count_next  = CW'(WIDTH - 1);
                    neg_q_next  = is_signed & (Dividend[WIDTH-1] ^ Divisor[WIDTH-1]);
                    neg_r_next  = is_signed & Dividend[WIDTH-1];
                    state_next  = BUSY;
                end
            end

            BUSY: begin
                if (!trial[WIDTH]) begin
                    rem_next    = trial[WIDTH-1:0];
                    quo_sr_next = {quo_sr[WIDTH-2:0], 1'b1};
                end else begin
                    rem_next    = {rem[WIDTH-2:0], quo_sr[WIDTH-1]};
                    quo_sr_next = {quo_sr[WIDTH-2:0], 1'b0};
                end
                count_next = count - CW'(1);
                if (count == '0) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count  <= '0;
            quo_sr <= '0;
            dvsr   <= '0;
            rem    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
        end else begin
            count  <= count_next;
            quo_sr <= quo_sr_next;
            dvsr   <= dvsr_next;
            rem    <= rem_next;
            neg_q  <= neg_q_next;
            neg_r  <= neg_r_next;
        end
    end

    assign Stall     = (state == BUSY);
    assign Quotient  = neg_q ? -quo_sr : quo_sr;
    assign Remainder = neg_r ? -rem    : rem;

endmodule
